// File: rtl/fpu_add_scheduler_if.sv
// Signal bundle between the FPU issue ports, the shared adder and the
// response consumer on one side, and the add scheduler on the other.
interface fpu_add_scheduler_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ-1:0]      req_sub;
  logic [XLEN-1:0]      add_a;
  logic [XLEN-1:0]      add_b;
  logic [XLEN-1:0]      add_result;
  logic                 add_overflow;
  logic                 add_underflow;
  logic                 add_exception;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_result;
  logic [2:0]           rsp_flags;
  logic                 busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_sub, add_result,
           add_overflow, add_underflow, add_exception, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_result,
           rsp_flags, busy
  );

  // Issue ports, adder and response consumer side.
  modport master (
    output req_valid, req_a, req_b, req_sub, add_result,
           add_overflow, add_underflow, add_exception, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_result,
           rsp_flags, busy
  );
endinterface

// File: rtl/fpu_add_scheduler.sv
// Round-robin scheduler sharing one combinational FP adder between NREQ
// requesters, with a tagged valid/ready response channel.
//
// state  | meaning
// IDLE   | no operation in flight, waiting for a request
// EXEC   | operands held on the adder, lat_cnt counting down
// RESP   | result captured, rsp_valid high until rsp_ready
module fpu_add_scheduler #(
  parameter int XLEN    = 32,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1,
  parameter int IDW     = 3
) (
  input logic                clk,
  input logic                rst,
  fpu_add_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [3:0]      lat_cnt_q, lat_cnt_d;
  logic [XLEN-1:0] add_a_q, add_a_d;
  logic [XLEN-1:0] add_b_q, add_b_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]      rsp_flags_q, rsp_flags_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;
  logic            accept_ok;
  logic            accept;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // A new operation may enter when idle, or when the pending response is
  // being consumed this very cycle.
  assign accept_ok = (state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready);
  assign accept    = !rst && grant_found && accept_ok;

  // One-hot accept to the winning requester.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant_idx] = 1'b1;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    lat_cnt_d    = lat_cnt_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      S_EXEC: begin
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else begin
          rsp_result_d = bus.add_result;
          rsp_flags_d  = {bus.add_overflow, bus.add_underflow, bus.add_exception};
          rsp_id_d     = id_q;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    // Accept overrides the RESP->IDLE exit to form the back-to-back path.
    if (accept) begin
      add_a_d   = bus.req_a[grant_idx*XLEN +: XLEN];
      add_b_d   = {bus.req_b[grant_idx*XLEN + XLEN-1] ^ bus.req_sub[grant_idx],
                   bus.req_b[grant_idx*XLEN +: XLEN-1]};
      id_d      = grant_idx;
      rr_ptr_d  = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      lat_cnt_d = 4'(ADD_LAT-1);
      state_d   = S_EXEC;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      lat_cnt_q    <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      lat_cnt_q    <= lat_cnt_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // Status outputs are forced low while reset is asserted.
  assign bus.rsp_valid  = !rst && (state_q == S_RESP);
  assign bus.busy       = !rst && (state_q != S_IDLE);
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Bench for fpu_add_scheduler: one instance with ADD_LAT=1, one with ADD_LAT=3.
// The shared adder is stood in for by a simple deterministic function.
module tb_fpu_add_scheduler;
  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        mode1, mode3;
  logic [31:0] const1, const3;
  logic [2:0]  cflags1, cflags3;

  fpu_add_scheduler_if #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) bus1();
  fpu_add_scheduler_if #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) bus3();

  fpu_add_scheduler #(.XLEN(XLEN), .NREQ(NREQ), .ADD_LAT(1), .IDW(IDW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fpu_add_scheduler #(.XLEN(XLEN), .NREQ(NREQ), .ADD_LAT(3), .IDW(IDW)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic [2:0] fflags(input logic [31:0] a, input logic [31:0] b);
    return {a[31] ^ b[31], a[0], b[1] ^ a[2]};
  endfunction

  function automatic logic [31:0] eff_b(input logic [31:0] b, input logic s);
    return {b[31] ^ s, b[30:0]};
  endfunction

  // Stand-in adder: either a fixed value or the function of the registered operands.
  assign bus1.add_result = mode1 ? const1 : fsum(bus1.add_a, bus1.add_b);
  assign {bus1.add_overflow, bus1.add_underflow, bus1.add_exception} = mode1 ? cflags1 : fflags(bus1.add_a, bus1.add_b);
  assign bus3.add_result = mode3 ? const3 : fsum(bus3.add_a, bus3.add_b);
  assign {bus3.add_overflow, bus3.add_underflow, bus3.add_exception} = mode3 ? cflags3 : fflags(bus3.add_a, bus3.add_b);

  task automatic set_op1(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus1.req_a[i*XLEN +: XLEN] = a;
    bus1.req_b[i*XLEN +: XLEN] = b;
    bus1.req_sub[i] = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus1.req_valid = '0; bus3.req_valid = '0;
    bus1.rsp_ready = 1'b0; bus3.rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.req_valid = '1; bus3.req_valid = '1;
    @(negedge clk); #1;
    n_checks++; if (bus1.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", bus1.req_ready); end
    n_checks++; if (bus3.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready3: got %b want 0000", bus3.req_ready); end
    n_checks++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus1.rsp_valid); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
    bus1.req_valid = '0; bus3.req_valid = '0;
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (bus1.add_a !== 32'h0) begin n_fail++; $display("FAIL reset_add_a: got %h want 0", bus1.add_a); end
    n_checks++; if (bus1.add_b !== 32'h0) begin n_fail++; $display("FAIL reset_add_b: got %h want 0", bus1.add_b); end
    n_checks++; if (bus1.rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result: got %h want 0", bus1.rsp_result); end
    n_checks++; if (bus1.rsp_id !== 3'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", bus1.rsp_id); end
    n_checks++; if (bus1.rsp_flags !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_flags: got %b want 000", bus1.rsp_flags); end
    n_checks++; if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got valid=%b busy=%b want 0 0", bus1.rsp_valid, bus1.busy); end
  endtask

  task automatic test_single_op();
    mode1 = 1'b1; const1 = 32'h40400000; cflags1 = 3'b000;
    @(negedge clk);
    set_op1(2, 32'h3F800000, 32'h40000000, 1'b0);
    bus1.req_valid = 4'b0100; bus1.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus1.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %b want 0100", bus1.req_ready); end
    @(negedge clk); bus1.req_valid = '0; #1;
    n_checks++; if (bus1.add_a !== 32'h3F800000) begin n_fail++; $display("FAIL single_add_a: got %h want 3f800000", bus1.add_a); end
    n_checks++; if (bus1.add_b !== 32'h40000000) begin n_fail++; $display("FAIL single_add_b: got %h want 40000000", bus1.add_b); end
    n_checks++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", bus1.rsp_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus1.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", bus1.rsp_valid); end
    n_checks++; if (bus1.rsp_id !== 3'd2) begin n_fail++; $display("FAIL single_rsp_id: got %0d want 2", bus1.rsp_id); end
    n_checks++; if (bus1.rsp_result !== 32'h40400000) begin n_fail++; $display("FAIL single_rsp_result: got %h want 40400000", bus1.rsp_result); end
    @(negedge clk); #1;
    n_checks++; if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got valid=%b busy=%b want 0 0", bus1.rsp_valid, bus1.busy); end
  endtask

  task automatic test_subtract();
    mode1 = 1'b1; const1 = 32'h40000000; cflags1 = 3'b010;
    @(negedge clk);
    set_op1(0, 32'h40400000, 32'h3F800000, 1'b1);
    bus1.req_valid = 4'b0001; bus1.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus1.req_ready !== 4'b0001) begin n_fail++; $display("FAIL sub_req_ready: got %b want 0001", bus1.req_ready); end
    @(negedge clk); bus1.req_valid = '0; #1;
    n_checks++; if (bus1.add_a !== 32'h40400000) begin n_fail++; $display("FAIL sub_add_a: got %h want 40400000", bus1.add_a); end
    n_checks++; if (bus1.add_b !== 32'hBF800000) begin n_fail++; $display("FAIL sub_add_b: got %h want bf800000", bus1.add_b); end
    @(negedge clk); #1;
    n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 3'd0) begin n_fail++; $display("FAIL sub_rsp: got valid=%b id=%0d want 1 0", bus1.rsp_valid, bus1.rsp_id); end
    n_checks++; if (bus1.rsp_result !== 32'h40000000 || bus1.rsp_flags !== 3'b010) begin n_fail++; $display("FAIL sub_rsp_data: got %h/%b want 40000000/010", bus1.rsp_result, bus1.rsp_flags); end
    @(negedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] a3, b3, a1, b1, r3, r1;
    logic        s3, s1;
    logic [2:0]  f3, f1;
    mode1 = 1'b0;
    a3 = $urandom; b3 = $urandom; s3 = 1'($urandom_range(1));
    a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(1));
    r3 = fsum(a3, eff_b(b3, s3)); f3 = fflags(a3, eff_b(b3, s3));
    r1 = fsum(a1, eff_b(b1, s1)); f1 = fflags(a1, eff_b(b1, s1));
    @(negedge clk);
    set_op1(3, a3, b3, s3);
    bus1.req_valid = 4'b1000; bus1.rsp_ready = 1'b0;
    #1;
    n_checks++; if (bus1.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_first_ready: got %b want 1000", bus1.req_ready); end
    @(negedge clk);
    bus1.req_valid = '0; set_op1(1, a1, b1, s1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); bus1.req_valid = 4'b0010; #1;
      n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 3'd3) begin n_fail++; $display("FAIL bp_hold_vid[%0d]: got valid=%b id=%0d want 1 3", c, bus1.rsp_valid, bus1.rsp_id); end
      n_checks++; if (bus1.rsp_result !== r3 || bus1.rsp_flags !== f3) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h/%b want %h/%b", c, bus1.rsp_result, bus1.rsp_flags, r3, f3); end
      n_checks++; if (bus1.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", c, bus1.req_ready); end
    end
    @(negedge clk); bus1.rsp_ready = 1'b1; #1;
    n_checks++; if (bus1.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_b2b_ready: got %b want 0010", bus1.req_ready); end
    @(negedge clk); bus1.req_valid = '0; #1;
    n_checks++; if (bus1.rsp_valid !== 1'b0 || bus1.add_a !== a1) begin n_fail++; $display("FAIL bp_b2b_exec: got valid=%b add_a=%h want 0 %h", bus1.rsp_valid, bus1.add_a, a1); end
    @(negedge clk); #1;
    n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 3'd1 || bus1.rsp_result !== r1 || bus1.rsp_flags !== f1) begin n_fail++; $display("FAIL bp_b2b_rsp: got v=%b id=%0d %h/%b want 1 1 %h/%b", bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flags, r1, f1); end
    @(negedge clk); #1;
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got busy=%b want 0", bus1.busy); end
  endtask

  task automatic test_contention();
    int grants, last_cyc;
    int exp_ids[$];
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    mode1 = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op1(i, $urandom, $urandom, 1'($urandom_range(1)));
    grants = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 30 && grants < 5; cyc++) begin
      @(negedge clk);
      bus1.req_valid = '1; bus1.rsp_ready = 1'b1;
      #1;
      if (bus1.rsp_valid === 1'b1) begin
        n_checks++; if (exp_ids.size() == 0 || bus1.rsp_id !== 3'(exp_ids[0])) begin n_fail++; $display("FAIL cont_rsp_id: got %0d want %0d", bus1.rsp_id, (exp_ids.size() != 0) ? exp_ids[0] : -1); end
        if (exp_ids.size() != 0) void'(exp_ids.pop_front());
      end
      if (bus1.req_ready !== '0) begin
        exp_rdy = '0; exp_rdy[grants % NREQ] = 1'b1;
        n_checks++; if (bus1.req_ready !== exp_rdy) begin n_fail++; $display("FAIL cont_order[%0d]: got %b want %b", grants, bus1.req_ready, exp_rdy); end
        if (grants > 0) begin
          n_checks++; if (cyc - last_cyc != 2) begin n_fail++; $display("FAIL cont_interval[%0d]: got %0d want 2", grants, cyc - last_cyc); end
        end
        exp_ids.push_back(grants % NREQ);
        last_cyc = cyc; grants++;
      end
    end
    n_checks++; if (grants != 5) begin n_fail++; $display("FAIL cont_grant_count: got %0d want 5", grants); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); bus1.req_valid = '0; #1;
      if (bus1.busy === 1'b0) break;
    end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL cont_drain: got busy=%b want 0", bus1.busy); end
  endtask

  task automatic test_latency();
    logic [31:0] a, c1;
    logic [2:0]  fl;
    a = $urandom; c1 = $urandom; fl = 3'($urandom_range(7));
    mode3 = 1'b1; const3 = ~c1; cflags3 = ~fl;
    @(negedge clk);
    bus3.req_a[1*XLEN +: XLEN] = a; bus3.req_b[1*XLEN +: XLEN] = $urandom; bus3.req_sub[1] = 1'b0;
    bus3.req_valid = 4'b0010; bus3.rsp_ready = 1'b0;
    #1;
    n_checks++; if (bus3.req_ready !== 4'b0010) begin n_fail++; $display("FAIL lat_req_ready: got %b want 0010", bus3.req_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus3.req_valid = '0;
      if (k == 3) begin const3 = c1; cflags3 = fl; end else const3 = c1 ^ 32'(k);
      #1;
      n_checks++; if (bus3.add_a !== a || bus3.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_exec[T+%0d]: got add_a=%h valid=%b want %h 0", k, bus3.add_a, bus3.rsp_valid, a); end
    end
    @(negedge clk); const3 = ~c1; cflags3 = ~fl; #1;
    n_checks++; if (bus3.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lat_rsp_valid: got %b want 1", bus3.rsp_valid); end
    n_checks++; if (bus3.rsp_result !== c1 || bus3.rsp_flags !== fl || bus3.rsp_id !== 3'd1) begin n_fail++; $display("FAIL lat_rsp_data: got %h/%b/%0d want %h/%b/1", bus3.rsp_result, bus3.rsp_flags, bus3.rsp_id, c1, fl); end
    @(negedge clk); bus3.rsp_ready = 1'b1; #1;
    n_checks++; if (bus3.rsp_result !== c1 || bus3.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lat_rsp_hold: got %h valid=%b want %h 1", bus3.rsp_result, bus3.rsp_valid, c1); end
    @(negedge clk); bus3.rsp_ready = 1'b0; #1;
    n_checks++; if (bus3.rsp_valid !== 1'b0 || bus3.busy !== 1'b0) begin n_fail++; $display("FAIL lat_done: got valid=%b busy=%b want 0 0", bus3.rsp_valid, bus3.busy); end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] a0, b0, r0;
    mode1 = 1'b0;
    a0 = $urandom; b0 = $urandom; r0 = fsum(a0, b0);
    @(negedge clk);
    set_op1(2, $urandom, $urandom, 1'b0);
    bus1.req_valid = 4'b0100; bus1.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus1.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rme_accept: got %b want 0100", bus1.req_ready); end
    @(negedge clk); bus1.req_valid = '0; rst = 1'b1; #1;
    n_checks++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rme_during: got valid=%b want 0", bus1.rsp_valid); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); rst = 1'b0; #1;
      n_checks++; if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rme_idle[%0d]: got valid=%b busy=%b want 0 0", c, bus1.rsp_valid, bus1.busy); end
    end
    @(negedge clk);
    set_op1(0, a0, b0, 1'b0); set_op1(3, $urandom, $urandom, 1'b0);
    bus1.req_valid = 4'b1001;
    #1;
    n_checks++; if (bus1.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rme_ptr_cleared: got %b want 0001", bus1.req_ready); end
    @(negedge clk); bus1.req_valid = '0; #1;
    @(negedge clk); #1;
    n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 3'd0 || bus1.rsp_result !== r0) begin n_fail++; $display("FAIL rme_next_op: got v=%b id=%0d %h want 1 0 %h", bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, r0); end
    @(negedge clk); #1;
  endtask

  task automatic test_random();
    logic            pend [NREQ];
    logic            offered [NREQ];
    logic [31:0]     pa [NREQ];
    logic [31:0]     pb [NREQ];
    logic            ps [NREQ];
    int              qid [$];
    logic [31:0]     qres [$];
    logic [2:0]      qfl [$];
    int              mptr, acc_cyc, exp_g, idx;
    logic            exp_valid, hs, can;
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    mode1 = 1'b0;
    mptr = 0; acc_cyc = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1; pa[i] = $urandom; pb[i] = $urandom; ps[i] = 1'($urandom_range(1));
        end
        offered[i] = pend[i] && ($urandom_range(3) != 0);
        bus1.req_valid[i] = offered[i];
        if (pend[i]) set_op1(i, pa[i], pb[i], ps[i]);
      end
      bus1.rsp_ready = ($urandom_range(3) != 0);
      #1;
      exp_valid = (qid.size() != 0) && (cyc - acc_cyc >= 2);
      n_checks++; if (bus1.rsp_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", cyc, bus1.rsp_valid, exp_valid); end
      if (exp_valid) begin
        n_checks++; if (bus1.rsp_id !== 3'(qid[0]) || bus1.rsp_result !== qres[0] || bus1.rsp_flags !== qfl[0]) begin n_fail++; $display("FAIL rnd_rsp_data[%0d]: got %0d/%h/%b want %0d/%h/%b", cyc, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flags, qid[0], qres[0], qfl[0]); end
      end
      hs = exp_valid && bus1.rsp_ready;
      exp_g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (exp_g < 0 && offered[idx]) exp_g = idx;
      end
      can = (exp_g >= 0) && (qid.size() == 0 || hs);
      exp_rdy = '0;
      if (can) exp_rdy[exp_g] = 1'b1;
      n_checks++; if (bus1.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", cyc, bus1.req_ready, exp_rdy); end
      if (hs) begin
        void'(qid.pop_front()); void'(qres.pop_front()); void'(qfl.pop_front());
      end
      if (can) begin
        qid.push_back(exp_g);
        qres.push_back(fsum(pa[exp_g], eff_b(pb[exp_g], ps[exp_g])));
        qfl.push_back(fflags(pa[exp_g], eff_b(pb[exp_g], ps[exp_g])));
        pend[exp_g] = 1'b0;
        mptr = (exp_g + 1) % NREQ;
        acc_cyc = cyc;
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); bus1.req_valid = '0; bus1.rsp_ready = 1'b1; #1;
      if (bus1.busy === 1'b0) break;
    end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: got busy=%b want 0", bus1.busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mode1 = 1'b0; mode3 = 1'b0;
    const1 = '0; const3 = '0; cflags1 = '0; cflags3 = '0;
    bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_sub = '0; bus1.rsp_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_sub = '0; bus3.rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_subtract();
    test_backpressure();
    test_contention();
    test_latency();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_add_scheduler.md
# fpu_add_scheduler

Round-robin scheduler that shares one single-precision floating-point adder (the combinational `A`/`B` → `result` add unit of the FPU) between `NREQ` requesters. It arbitrates the requesters, registers the winning operands onto the adder inputs and holds them for `ADD_LAT` cycles. It then captures the result and status flags and returns them on a single tagged response channel with valid/ready backpressure. It sits between the FPU front-end issue ports and the shared adder instance.

## Interface

Parameters:
- `XLEN`, 32: operand width (IEEE-754 single).
- `NREQ`, 4: number of requesters, 2..8.
- `ADD_LAT`, 1: cycles the adder inputs are held before the result is sampled, 1..15.
- `IDW`, 3: width of the requester ID; must satisfy 2^IDW ≥ NREQ.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in NREQ: per-requester operation valid.
- `req_ready` out NREQ: per-requester accept; at most one bit is high; combinational from `req_valid`, state and `rr_ptr`.
- `req_a` in NREQ*XLEN: packed A operands; requester i uses bits [i*XLEN +: XLEN].
- `req_b` in NREQ*XLEN: packed B operands, same packing.
- `req_sub` in NREQ: 1 = A−B, 0 = A+B.
- `add_a` out XLEN: registered operand A to the shared adder.
- `add_b` out XLEN: registered operand B to the shared adder; sign bit already flipped for subtract.
- `add_result` in XLEN: adder result.
- `add_overflow`, `add_underflow`, `add_exception` in 1 each: adder status.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out IDW: index of the requester that issued the operation.
- `rsp_result` out XLEN: captured result.
- `rsp_flags` out 3: {overflow, underflow, exception}, captured together with the result.
- `busy` out 1: high in EXEC or RESP.

## Operation

- States: IDLE, EXEC, RESP.
- Grant: winner g is the first index with `req_valid` set, searching from `rr_ptr` upward modulo NREQ. `req_ready[g]`=1 only in IDLE, or in RESP while `rsp_ready`=1.
- Accept (`req_valid[g]` & `req_ready[g]`):
  - `add_a` ← A[g]; `add_b` ← {B[g][31]^`req_sub`[g], B[g][30:0]}.
  - ID register ← g; `rr_ptr` ← (g+1) mod NREQ; `lat_cnt` ← ADD_LAT−1; next state EXEC.
- EXEC: `add_a`/`add_b` held stable.
  - `lat_cnt`≠0: decrement.
  - `lat_cnt`=0: `rsp_result`/`rsp_flags` ← adder outputs; `rsp_id` ← ID register; next state RESP.
- RESP: `rsp_valid`=1. Response registers are stable until the handshake.
  - `rsp_ready`=0: stay in RESP.
  - `rsp_ready`=1 and no request pending: go to IDLE.
  - `rsp_ready`=1 and a request is pending: accept it in the same cycle (back-to-back path) and go to EXEC.
- `rr_ptr` changes only on accept. Requests that are not granted wait; no request is dropped and no request is accepted twice.
- `req_valid` deasserting before grant is legal; the arbiter simply re-evaluates.
- `add_a`/`add_b` keep their last values in IDLE and RESP.

## Timing

- Reset values: state IDLE; `rr_ptr`, `lat_cnt`, `add_a`, `add_b`, `rsp_result`, `rsp_flags` and `rsp_id` = 0; `rsp_valid`, `busy` and `req_ready` = 0 during the reset cycle.
- Reset asserted in any state discards the in-flight operation. No response is produced for it.
- Latency, with the accept at cycle T:
  - adder inputs are valid from T+1;
  - the result is sampled at the end of T+ADD_LAT;
  - `rsp_valid` rises at T+ADD_LAT+1.
- Sustained throughput with `rsp_ready` held at 1: one operation per ADD_LAT+1 cycles.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, all outputs hold and `req_ready`=0.
- Fairness: under continuous requests from all requesters, each is granted exactly once in every NREQ consecutive grants.
- Wrap-around: after granting index NREQ−1, `rr_ptr`=0.

## Test plan

- Single op, ADD_LAT=1: requester 2 issues 0x3F800000 + 0x40000000 at T.
  - Required: `req_ready`=4'b0100 at T; `add_a`=0x3F800000 and `add_b`=0x40000000 at T+1; `rsp_valid`=1 at T+2 with `rsp_id`=2, `rsp_result`=adder output (0x40400000).
- Subtract: requester 0, A=0x40400000, B=0x3F800000, `req_sub`=1.
  - Required: `add_b`=0xBF800000 and `rsp_id`=0.
- Contention, NREQ=4: all four `req_valid` held high, `rsp_ready`=1, from reset.
  - Required: grant order 0,1,2,3,0; a new accept every ADD_LAT+1 cycles.
- Backpressure: `rsp_ready`=0 for 5 cycles while in RESP.
  - Required: `rsp_valid`, `rsp_result` and `rsp_id` stable; `req_ready`=0.
  - On `rsp_ready`=1 with requester 1 pending: requester 1 is accepted in that same cycle.
- Latency, ADD_LAT=3: accept at T.
  - Required: `add_a` stable over T+1..T+3; `rsp_valid` rises at T+4; the result is sampled from T+3 (the bench changes `add_result` at T+4 and the response must not change).
- Reset mid-EXEC: `rst` asserted 1 cycle during EXEC.
  - Required: the next cycle is IDLE with `rsp_valid`=0 and `rr_ptr`=0; no response for the aborted operation; the next request is handled normally.
